// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_BOOT_HI = 3'd0,
        S_BOOT_LO = 3'd1,
        S_RUN     = 3'd2,
        S_INT_HI  = 3'd3,
        S_INT_LO  = 3'd4
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage: redirect priority mux plus the PC+1 adder.
module fetch_pc_sel #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_choose_memory,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    input  logic              int_want,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              redirect,
    output logic              hold,
    output logic              int_enter
);

    always_comb begin
        pc_plus1  = pc + ADDR_W'(1);
        redirect  = pc_choose_memory | jump_taken;
        hold      = !redirect && stall;
        int_enter = !redirect && !stall && int_want;

        // Interrupt entry keeps PC so it becomes the return address.
        if (pc_choose_memory)       pc_next = mem_pc;
        else if (jump_taken)        pc_next = jump_target;
        else if (stall || int_want) pc_next = pc;
        else                        pc_next = pc_plus1;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, boot/interrupt vector loading and the IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch and stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              ADDR_W  = 32,
    parameter int              INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RST_VEC = 32'd0,
    parameter logic [ADDR_W-1:0] INT_VEC = 32'd2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               fetch_stall_cu,
    input  logic               hazard_stall,
    input  logic               flush_fetch,
    input  logic               jump_taken,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               pc_choose_memory,
    input  logic [ADDR_W-1:0]  mem_pc,
    input  logic               interrupt_req,
    output logic [INSTR_W-1:0] instruction_f,
    output logic [ADDR_W-1:0]  pc_f,
    output logic               interrupt_signal_f,
    output logic               boot_done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] vec_hi_q, vec_hi_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_f_q, pc_f_d;
    logic               int_sig_q, int_sig_d;
    logic               boot_done_q, boot_done_d;
    logic               int_pending_q, int_pending_d;

    logic [ADDR_W-1:0]  pc_next, pc_plus1;
    logic               redirect, hold, int_enter, stall, int_want;

    assign stall    = fetch_stall_cu | hazard_stall;
    assign int_want = int_pending_q | interrupt_req;

    fetch_pc_sel #(.ADDR_W(ADDR_W)) u_pc_sel (
        .pc               (pc_q),
        .pc_choose_memory (pc_choose_memory),
        .mem_pc           (mem_pc),
        .jump_taken       (jump_taken),
        .jump_target      (jump_target),
        .stall            (stall),
        .int_want         (int_want),
        .pc_next          (pc_next),
        .pc_plus1         (pc_plus1),
        .redirect         (redirect),
        .hold             (hold),
        .int_enter        (int_enter)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        vec_hi_d      = vec_hi_q;
        instr_d       = instr_q;
        pc_f_d        = pc_f_q;
        int_sig_d     = int_sig_q;
        boot_done_d   = boot_done_q;
        int_pending_d = int_pending_q;
        imem_addr     = pc_q;

        case (state_q)
            S_BOOT_HI: begin
                imem_addr = RST_VEC;
                vec_hi_d  = imem_rdata;
                state_d   = S_BOOT_LO;
            end
            S_BOOT_LO: begin
                imem_addr   = RST_VEC + ADDR_W'(1);
                pc_d        = ADDR_W'({vec_hi_q, imem_rdata});
                boot_done_d = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                imem_addr     = pc_q;
                pc_d          = pc_next;
                int_pending_d = int_enter ? 1'b0 : int_want;
                if (int_enter) state_d = S_INT_HI;

                if (flush_fetch || redirect) begin
                    instr_d   = INSTR_W'(NOP_INSTR);
                    pc_f_d    = '0;
                    int_sig_d = 1'b0;
                end else if (!hold) begin
                    if (int_enter) begin
                        instr_d   = INSTR_W'(NOP_INSTR);
                        pc_f_d    = pc_q;
                        int_sig_d = 1'b1;
                    end else begin
                        instr_d   = imem_rdata;
                        pc_f_d    = pc_plus1;
                        int_sig_d = 1'b0;
                    end
                end
            end
            S_INT_HI, S_INT_LO: begin
                // Pipeline drains with NOPs; redirects and new requests are absorbed here.
                instr_d   = INSTR_W'(NOP_INSTR);
                pc_f_d    = '0;
                int_sig_d = 1'b0;
                if (state_q == S_INT_HI) begin
                    imem_addr = INT_VEC;
                    vec_hi_d  = imem_rdata;
                    state_d   = S_INT_LO;
                end else begin
                    imem_addr = INT_VEC + ADDR_W'(1);
                    pc_d      = ADDR_W'({vec_hi_q, imem_rdata});
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_BOOT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_BOOT_HI;
            pc_q          <= '0;
            vec_hi_q      <= '0;
            instr_q       <= INSTR_W'(NOP_INSTR);
            pc_f_q        <= '0;
            int_sig_q     <= 1'b0;
            boot_done_q   <= 1'b0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            vec_hi_q      <= vec_hi_d;
            instr_q       <= instr_d;
            pc_f_q        <= pc_f_d;
            int_sig_q     <= int_sig_d;
            boot_done_q   <= boot_done_d;
            int_pending_q <= int_pending_d;
        end
    end

    assign instruction_f      = instr_q;
    assign pc_f               = pc_f_q;
    assign interrupt_signal_f = int_sig_q;
    assign boot_done          = boot_done_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_stall_q, perf_stall_d;
    logic        fetch_load;

    always_comb begin
        fetch_load   = (state_q == S_RUN) && !flush_fetch && !redirect && !hold && !int_enter;
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (fetch_load && perf_fetch_q != 16'hFFFF)
            perf_fetch_d = perf_fetch_q + 16'd1;
        if (state_q == S_RUN && stall && perf_stall_q != 16'hFFFF)
            perf_stall_d = perf_stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences and a randomized run against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_VEC = 32'd0;
    localparam logic [31:0] INT_VEC = 32'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        fetch_stall_cu = 0, hazard_stall = 0, flush_fetch = 0;
    logic        jump_taken = 0, pc_choose_memory = 0, interrupt_req = 0;
    logic [31:0] jump_target = '0, mem_pc = '0;
    logic [15:0] instruction_f;
    logic [31:0] pc_f;
    logic        interrupt_signal_f, boot_done;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Memory: reset vector {0,0x10}, interrupt vector {0,0x100}, elsewhere a pattern of the address.
    function automatic logic [15:0] rd(input logic [31:0] a);
        case (a)
            32'd0:   return 16'h0000;
            32'd1:   return 16'h0010;
            32'd2:   return 16'h0000;
            32'd3:   return 16'h0100;
            default: return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign imem_rdata = rd(imem_addr);

    fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .fetch_stall_cu     (fetch_stall_cu),
        .hazard_stall       (hazard_stall),
        .flush_fetch        (flush_fetch),
        .jump_taken         (jump_taken),
        .jump_target        (jump_target),
        .pc_choose_memory   (pc_choose_memory),
        .mem_pc             (mem_pc),
        .interrupt_req      (interrupt_req),
        .instruction_f      (instruction_f),
        .pc_f               (pc_f),
        .interrupt_signal_f (interrupt_signal_f),
        .boot_done          (boot_done)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt     (perf_fetch_cnt),
        .perf_stall_cnt     (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit req, input bit scu, input bit haz, input bit fl,
                         input bit jt, input logic [31:0] tgt, input bit pcm, input logic [31:0] mpc);
        reset            = rst;
        interrupt_req    = req;
        fetch_stall_cu   = scu;
        hazard_stall     = haz;
        flush_fetch      = fl;
        jump_taken       = jt;
        jump_target      = tgt;
        pc_choose_memory = pcm;
        mem_pc           = mpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ea, input logic [15:0] ei,
                           input logic [31:0] epf, input bit es, input bit eb);
        chk({tag, ".imem_addr"}, imem_addr, ea);
        chk({tag, ".instr"}, {16'h0, instruction_f}, {16'h0, ei});
        chk({tag, ".pc_f"}, pc_f, epf);
        chk({tag, ".int_sig"}, {31'h0, interrupt_signal_f}, {31'h0, es});
        chk({tag, ".boot_done"}, {31'h0, boot_done}, {31'h0, eb});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          req, scu, haz, fl, jt, pcm;
        logic [31:0] tgt, mpc;
        logic [31:0] ea;
        logic [15:0] ei;
        logic [31:0] epf;
        bit          es, eb;
    } vec_t;

    function automatic vec_t mk(input bit req, input bit scu, input bit haz, input bit fl,
                                input bit jt, input logic [31:0] tgt, input bit pcm, input logic [31:0] mpc,
                                input logic [31:0] ea, input logic [15:0] ei, input logic [31:0] epf,
                                input bit es, input bit eb);
        vec_t v;
        v.req = req; v.scu = scu; v.haz = haz; v.fl = fl; v.jt = jt; v.tgt = tgt;
        v.pcm = pcm; v.mpc = mpc; v.ea = ea; v.ei = ei; v.epf = epf; v.es = es; v.eb = eb;
        return v;
    endfunction

    vec_t tbl[23];

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_pcf, m_vec;
    logic [15:0] m_instr;
    bit          m_sig, m_bd, m_pend, m_boot;
    int          m_busy;

    function automatic logic [31:0] m_addr();
        return (m_busy > 0) ? m_vec + 32'(2 - m_busy) : m_pc;
    endfunction

    task automatic model_step();
        logic [31:0] old;
        bit redirect, stall, want;
        if (!reset) begin
            m_pc = '0; m_instr = '0; m_pcf = '0; m_sig = 0; m_bd = 0;
            m_pend = 0; m_busy = 2; m_vec = RST_VEC; m_boot = 1;
        end else if (m_busy > 0) begin
            // Vector fetch in progress: two reads, PC taken from both halves on the second.
            if (m_busy == 1) begin
                m_pc = {rd(m_vec), rd(m_vec + 32'd1)};
                if (m_boot) m_bd = 1;
            end
            m_instr = '0; m_pcf = '0; m_sig = 0;
            m_busy--;
        end else begin
            old      = m_pc;
            redirect = pc_choose_memory || jump_taken;
            stall    = fetch_stall_cu || hazard_stall;
            want     = m_pend || interrupt_req;
            if (flush_fetch || redirect) begin
                m_instr = '0; m_pcf = '0; m_sig = 0;
            end else if (!stall) begin
                if (want) begin
                    m_instr = '0; m_pcf = old; m_sig = 1;
                end else begin
                    m_instr = rd(old); m_pcf = old + 32'd1; m_sig = 0;
                end
            end
            m_pend = want;
            if (pc_choose_memory)  m_pc = mem_pc;
            else if (jump_taken)   m_pc = jump_target;
            else if (stall)        m_pc = old;
            else if (want) begin
                m_busy = 2; m_vec = INT_VEC; m_boot = 0; m_pend = 0;
            end else               m_pc = old + 32'd1;
        end
    endtask

    task automatic cyc(input string tag, input bit rst, input bit req, input bit scu, input bit haz,
                       input bit fl, input bit jt, input logic [31:0] tgt, input bit pcm, input logic [31:0] mpc);
        drive(rst, req, scu, haz, fl, jt, tgt, pcm, mpc);
        model_step();
        tick();
        chk_out(tag, m_addr(), m_instr, m_pcf, m_sig, m_bd);
    endtask

    initial begin
        //        req scu haz fl jt tgt            pcm mpc    | addr          instr     pc_f      sig bd
        tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h1,        16'h0000, 32'h0,     0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h10,       16'h0000, 32'h0,     0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h11,       16'h5A4A, 32'h11,    0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h12,       16'h5A4B, 32'h12,    0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h12,       16'h5A4B, 32'h12,    0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h12,       16'h5A4B, 32'h12,    0, 1);
        tbl[6]  = mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h12,       16'h5A4B, 32'h12,    0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h13,       16'h5A48, 32'h13,    0, 1);
        tbl[8]  = mk(0, 0, 1, 1, 0, 32'h0,        0, 32'h0,  32'h13,       16'h0000, 32'h0,     0, 1);
        tbl[9]  = mk(0, 1, 0, 0, 1, 32'h40,       0, 32'h0,  32'h40,       16'h0000, 32'h0,     0, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 32'h80,       1, 32'h20, 32'h20,       16'h0000, 32'h0,     0, 1);
        tbl[11] = mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h2,        16'h0000, 32'h20,    1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h3,        16'h0000, 32'h0,     0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h100,      16'h0000, 32'h0,     0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h101,      16'h5B5A, 32'h101,   0, 1);
        tbl[15] = mk(0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 32'h0,  32'hFFFFFFFF, 16'h0000, 32'h0,     0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,        16'hA5A5, 32'h0,     0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h1,        16'h0000, 32'h1,     0, 1);
        tbl[18] = mk(1, 1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h1,        16'h0000, 32'h1,     0, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h2,        16'h0000, 32'h1,     1, 1);
        tbl[20] = mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h3,        16'h0000, 32'h0,     0, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h100,      16'h0000, 32'h0,     0, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h101,      16'h5B5A, 32'h101,   0, 1);

        // Reset state
        drive(0, 0, 0, 0, 0, 0, '0, 0, '0);
        repeat (2) tick();
        chk_out("reset", 32'h0, 16'h0000, 32'h0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            drive(1, tbl[i].req, tbl[i].scu, tbl[i].haz, tbl[i].fl, tbl[i].jt, tbl[i].tgt, tbl[i].pcm, tbl[i].mpc);
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].ei, tbl[i].epf, tbl[i].es, tbl[i].eb);
        end

        // Reset landing in the middle of an interrupt vector load
        drive(1, 1, 0, 0, 0, 0, '0, 0, '0);
        tick();
        chk_out("int_entry", 32'h2, 16'h0000, 32'h101, 1, 1);
        drive(1, 0, 0, 0, 0, 0, '0, 0, '0);
        tick();
        chk_out("int_lo", 32'h3, 16'h0000, 32'h0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, '0, 0, '0);
        tick();
        chk_out("rst_mid_int", 32'h0, 16'h0000, 32'h0, 0, 0);

        // Performance sequence: 5 fetches then 2 stalls after a clean boot
        cyc("perf_rst", 0, 0, 0, 0, 0, 0, '0, 0, '0);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_rst", {16'h0, perf_fetch_cnt}, 32'd0);
        chk("perf_stall_rst", {16'h0, perf_stall_cnt}, 32'd0);
`endif
        repeat (2) cyc("perf_boot", 1, 0, 0, 0, 0, 0, '0, 0, '0);
        repeat (5) cyc("perf_fetch", 1, 0, 0, 0, 0, 0, '0, 0, '0);
        repeat (2) cyc("perf_stall", 1, 0, 1, 0, 0, 0, '0, 0, '0);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", {16'h0, perf_fetch_cnt}, 32'd5);
        chk("perf_stall_cnt", {16'h0, perf_stall_cnt}, 32'd2);
`endif

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt, mpc;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
            mpc = $urandom_range(0, 4095);
            cyc("rand",
                ($urandom_range(0, 299) != 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) == 0), tgt,
                ($urandom_range(0, 19) == 0), mpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
